// File: rtl/head_crc_framer_if.sv
`default_nettype none
// ============================================================================
// head_crc_framer_if : byte-in, CRC-feed and framed-out signal bundle
// Rev 1.0
// ============================================================================
interface head_crc_framer_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  crc_data;
  logic        crc_valid;
  logic [15:0] crc_in;
  logic        crc_in_valid;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_sop;
  logic        m_eop;
  logic        err_ovf;
  logic        err_crc_to;

  // Framer side
  modport master (
    input  s_data, s_valid, crc_in, crc_in_valid, m_ready,
    output s_ready, crc_data, crc_valid, m_data, m_valid, m_sop, m_eop,
           err_ovf, err_crc_to
  );

  // Peer side: byte source, CRC engine and downstream sink
  modport slave (
    output s_data, s_valid, crc_in, crc_in_valid, m_ready,
    input  s_ready, crc_data, crc_valid, m_data, m_valid, m_sop, m_eop,
           err_ovf, err_crc_to
  );
endinterface
`default_nettype wire

// File: rtl/head_crc_framer.sv
`default_nettype none
// ============================================================================
// head_crc_framer : buffers a header burst, feeds it to the CRC16 engine,
//                   then emits header + CRC (high byte first) with sop/eop.
// Rev 1.0
// ============================================================================
module head_crc_framer #(
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = 6,
  parameter int CRC_TO  = 15
) (
  input  wire logic          clk_in,
  input  wire logic          rst_n,
  head_crc_framer_if.master  bus
);
  localparam int AW   = $clog2(MAX_LEN);
  localparam int TO_W = $clog2(CRC_TO + 1);
  localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_LEN);
  localparam logic [TO_W-1:0]  c_TO_LAST = TO_W'(CRC_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_CRC, S_SEND_HDR, S_SEND_CRC_H, S_SEND_CRC_L
  } state_t;

  state_t           r_state;
  logic [7:0]       r_buf [MAX_LEN];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rd;
  logic [TO_W-1:0]  r_timer;
  logic             r_ovf;
  logic [15:0]      r_crc_q;
  logic             r_s_ready;
  logic             r_crc_valid;
  logic [7:0]       r_crc_data;
  logic             r_m_valid;
  logic [7:0]       r_m_data;
  logic             r_m_sop;
  logic             r_m_eop;
  logic             r_err_ovf;
  logic             r_err_crc_to;

  logic             w_accept;
  logic             w_buf_we;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_rd_nxt;
  logic             w_last_hdr;

  // s_ready is only high in IDLE/LOAD, so an accept implies one of those states
  assign w_accept   = bus.s_valid & r_s_ready;
  assign w_buf_we   = w_accept & ((r_state == S_IDLE) | (r_cnt < c_MAX_CNT));
  assign w_wr_addr  = (r_state == S_IDLE) ? '0 : r_cnt[AW-1:0];
  assign w_rd_nxt   = r_rd[AW-1:0] + AW'(1);
  assign w_last_hdr = (r_rd == (r_cnt - CNT_W'(1)));

  always_ff @(posedge clk_in) begin
    if (w_buf_we) begin
      r_buf[w_wr_addr] <= bus.s_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rd         <= '0;
      r_timer      <= '0;
      r_ovf        <= 1'b0;
      r_crc_q      <= '0;
      r_s_ready    <= 1'b1;
      r_crc_valid  <= 1'b0;
      r_crc_data   <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_sop      <= 1'b0;
      r_m_eop      <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_err_crc_to <= 1'b0;
    end else begin
      r_crc_data   <= bus.s_data;
      r_crc_valid  <= w_accept;
      r_err_ovf    <= 1'b0;
      r_err_crc_to <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.s_valid) begin
            r_cnt   <= CNT_W'(1);
            r_ovf   <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.s_valid) begin
            if (r_cnt < c_MAX_CNT) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_ovf <= 1'b1;
            end
          end else begin
            r_s_ready <= 1'b0;
            r_timer   <= '0;
            r_state   <= S_WAIT_CRC;
          end
        end
        S_WAIT_CRC: begin
          if (bus.crc_in_valid) begin
            if (r_ovf) begin
              r_err_ovf <= 1'b1;
              r_ovf     <= 1'b0;
              r_s_ready <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_crc_q   <= bus.crc_in;
              r_rd      <= '0;
              r_m_valid <= 1'b1;
              r_m_sop   <= 1'b1;
              r_m_data  <= r_buf[0];
              r_state   <= S_SEND_HDR;
            end
          end else if (r_timer == c_TO_LAST) begin
            r_err_crc_to <= 1'b1;
            r_ovf        <= 1'b0;
            r_s_ready    <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_timer <= r_timer + TO_W'(1);
          end
        end
        S_SEND_HDR: begin
          if (bus.m_ready) begin
            r_m_sop <= 1'b0;
            if (w_last_hdr) begin
              r_m_data <= r_crc_q[15:8];
              r_state  <= S_SEND_CRC_H;
            end else begin
              r_rd     <= r_rd + CNT_W'(1);
              r_m_data <= r_buf[w_rd_nxt];
            end
          end
        end
        S_SEND_CRC_H: begin
          if (bus.m_ready) begin
            r_m_data <= r_crc_q[7:0];
            r_m_eop  <= 1'b1;
            r_state  <= S_SEND_CRC_L;
          end
        end
        S_SEND_CRC_L: begin
          if (bus.m_ready) begin
            r_m_data  <= '0;
            r_m_eop   <= 1'b0;
            r_m_valid <= 1'b0;
            r_rd      <= '0;
            r_s_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ready    = r_s_ready;
  assign bus.crc_data   = r_crc_data;
  assign bus.crc_valid  = r_crc_valid;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_data     = r_m_data;
  assign bus.m_sop      = r_m_sop;
  assign bus.m_eop      = r_m_eop;
  assign bus.err_ovf    = r_err_ovf;
  assign bus.err_crc_to = r_err_crc_to;

endmodule
`default_nettype wire

// File: tb/tb_head_crc_framer.sv
`default_nettype none
// ============================================================================
// tb_head_crc_framer : directed scoreboard bench with a CRC engine stub
// Rev 1.0
// ============================================================================
module tb_head_crc_framer;
  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  head_crc_framer_if bus_if ();

  head_crc_framer #(.MAX_LEN(32), .CNT_W(6), .CRC_TO(15)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus_if)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [9:0]  exp_q[$];      // {sop, eop, data}
  logic [7:0]  crc_exp_q[$];
  logic [7:0]  hdr[$];
  int          exp_cv_len = 0;
  logic [15:0] stub_crc   = '0;
  bit          stub_en    = 1'b1;
  int          sop_cyc = -1, eop_cyc = -1, ovf_cyc = -1, to_cyc = -1;
  int          ovf_cnt = 0, to_cnt = 0;
  int          k = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop, stall stability, error pulse capture
  logic        prev_stall = 1'b0;
  logic [10:0] held = '0;
  always @(negedge clk_in) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {bus_if.m_valid, bus_if.m_sop, bus_if.m_eop, bus_if.m_data}, held);
      if (bus_if.m_valid && bus_if.m_sop && sop_cyc < 0) sop_cyc = cyc;
      if (bus_if.m_valid && bus_if.m_ready) begin
        if (bus_if.m_eop) eop_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_out: observed %0h expected none",
                 {bus_if.m_sop, bus_if.m_eop, bus_if.m_data});
        end else begin
          chk("out_byte", {bus_if.m_sop, bus_if.m_eop, bus_if.m_data}, exp_q.pop_front());
        end
      end
      prev_stall = bus_if.m_valid && !bus_if.m_ready;
      held       = {bus_if.m_valid, bus_if.m_sop, bus_if.m_eop, bus_if.m_data};
      if (bus_if.err_ovf) begin ovf_cnt++; ovf_cyc = cyc; end
      if (bus_if.err_crc_to) begin to_cnt++; to_cyc = cyc; end
    end
  end

  // CRC engine stub: checks the feed, answers two cycles after the burst ends
  initial begin : crc_stub
    int run;
    run = 0;
    bus_if.crc_in       = '0;
    bus_if.crc_in_valid = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        run = 0;
      end else if (bus_if.crc_valid) begin
        run++;
        if (crc_exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL crc_feed_unexpected: observed %0h expected none", bus_if.crc_data);
        end else begin
          chk("crc_feed", bus_if.crc_data, crc_exp_q.pop_front());
        end
      end else if (run != 0) begin
        chk("crc_valid_run", run, exp_cv_len);
        run = 0;
        if (stub_en) begin
          @(posedge clk_in); #1;
          bus_if.crc_in       = stub_crc;
          bus_if.crc_in_valid = 1'b1;
          @(posedge clk_in); #1;
          bus_if.crc_in_valid = 1'b0;
        end
      end
    end
  end

  task automatic send_frame(input logic [15:0] crc, input bit exp_out);
    sop_cyc    = -1;
    eop_cyc    = -1;
    stub_crc   = crc;
    exp_cv_len = hdr.size();
    foreach (hdr[i]) begin
      crc_exp_q.push_back(hdr[i]);
      if (exp_out) exp_q.push_back({(i == 0), 1'b0, hdr[i]});
    end
    if (exp_out) begin
      exp_q.push_back({2'b00, crc[15:8]});
      exp_q.push_back({2'b01, crc[7:0]});
    end
    foreach (hdr[i]) begin
      chk("s_ready_load", bus_if.s_ready, 1);
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = hdr[i];
      @(posedge clk_in); #1;
    end
    bus_if.s_valid = 1'b0;
    k = cyc;
  endtask

  task automatic drain(input bit toggle);
    int ph;
    ph = 0;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
      bus_if.m_ready = toggle ? (ph % 3 == 0) : 1'b1;
      ph++;
      @(posedge clk_in); #1;
    end
    chk("drain_empty", exp_q.size(), 0);
    bus_if.m_ready = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"},   bus_if.s_ready, 1);
    chk({tag, "_m_valid"},   bus_if.m_valid, 0);
    chk({tag, "_m_data"},    bus_if.m_data, 0);
    chk({tag, "_crc_valid"}, bus_if.crc_valid, 0);
    chk({tag, "_crc_data"},  bus_if.crc_data, 0);
    chk({tag, "_flags"},     {bus_if.m_sop, bus_if.m_eop, bus_if.err_ovf, bus_if.err_crc_to}, 0);
  endtask

  initial begin : main
    int ovf0, to0;
    bit hit;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    bus_if.m_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk_in); #1;

    // 4-byte frame, m_ready held high
    hdr = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(16'hBEEF, 1'b1);
    drain(1'b0);
    chk("t1_sop_latency", sop_cyc, k + 3);
    chk("t1_eop_cycle", eop_cyc, k + 8);
    chk("t1_s_ready_after", bus_if.s_ready, 1);

    // Same frame with back-pressure
    send_frame(16'hBEEF, 1'b1);
    drain(1'b1);
    chk("t2_sop_latency", sop_cyc, k + 3);

    // 1-byte frame
    hdr = '{8'hA5};
    send_frame(16'h1234, 1'b1);
    drain(1'b0);
    chk("t3_sop_latency", sop_cyc, k + 3);
    chk("t3_eop_cycle", eop_cyc, k + 5);

    // 34-byte frame overflows and is dropped
    hdr.delete();
    for (int i = 0; i < 34; i++) hdr.push_back(8'(8'h40 + i));
    ovf0 = ovf_cnt;
    send_frame(16'h5555, 1'b0);
    for (int t = 0; t < 20 && ovf_cnt == ovf0; t++) begin
      @(posedge clk_in); #1;
    end
    repeat (3) @(posedge clk_in);
    #1;
    chk("t4_ovf_pulses", ovf_cnt - ovf0, 1);
    chk("t4_ovf_cycle", ovf_cyc, k + 3);
    chk("t4_s_ready", bus_if.s_ready, 1);
    hdr = '{8'h01, 8'h02};
    send_frame(16'hABCD, 1'b1);
    drain(1'b0);
    chk("t4_next_sop", sop_cyc, k + 3);

    // CRC never returns; bytes offered during WAIT_CRC are ignored
    stub_en = 1'b0;
    to0 = to_cnt;
    hdr = '{8'h61, 8'h62};
    send_frame(16'h0000, 1'b0);
    @(posedge clk_in); #1;
    chk("t5_s_ready_wait", bus_if.s_ready, 0);
    bus_if.s_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      bus_if.s_valid = 1'b1;
      @(posedge clk_in); #1;
    end
    bus_if.s_valid = 1'b0;
    for (int t = 0; t < 30 && to_cnt == to0; t++) begin
      @(posedge clk_in); #1;
    end
    chk("t5_to_cycle", to_cyc, k + 16);
    chk("t5_s_ready_next", bus_if.s_ready, 1);
    repeat (3) @(posedge clk_in);
    #1;
    chk("t5_to_pulses", to_cnt - to0, 1);
    stub_en = 1'b1;

    // Reset while the second header byte is on the output
    hdr = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_frame(16'h0F0F, 1'b1);
    hit = 1'b0;
    for (int t = 0; t < 20 && !hit; t++) begin
      @(negedge clk_in);
      hit = bus_if.m_valid && (bus_if.m_data == 8'hC2);
    end
    chk("t6_reached_byte2", {bus_if.m_valid, bus_if.m_data}, {1'b1, 8'hC2});
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async_rst");
    exp_q.delete();
    crc_exp_q.delete();
    @(posedge clk_in); #3;
    rst_n = 1'b1;
    @(posedge clk_in); #1;
    hdr = '{8'hD1, 8'hD2};
    send_frame(16'h2468, 1'b1);
    drain(1'b0);
    chk("t6_sop_latency", sop_cyc, k + 3);
    chk("t6_eop_cycle", eop_cyc, k + 6);

    repeat (4) @(posedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/head_crc_framer.md
# head_crc_framer

Downlink header framer placed directly downstream of the header CRC16 engine. It accepts a contiguous burst of header bytes and buffers them. While buffering, it forwards each byte, one cycle later, to the CRC16 engine's byte input. It then latches the 16-bit CRC result and emits the header followed by the CRC (high byte first) on a valid/ready output stream with start/end-of-frame markers.

## Interface
Parameters:
- MAX_LEN, 32: maximum header bytes buffered per frame (power of two, ≥2).
- CNT_W, 6: counter width; must hold MAX_LEN.
- CRC_TO, 15: cycles allowed in WAIT_CRC before timeout.

Ports:
- clk_in  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  8  header byte.
- s_valid  in  1  byte present; a frame is one maximal run of s_valid high.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- crc_data  out  8  to CRC engine data_in.
- crc_valid  out  1  to CRC engine valid_in.
- crc_in  in  16  from CRC engine crc_out (already inverted).
- crc_in_valid  in  1  from CRC engine crc_out_valid; one-cycle pulse.
- m_data  out  8  output byte.
- m_valid  out  1  output byte present.
- m_ready  in  1  downstream accept.
- m_sop  out  1  with first header byte.
- m_eop  out  1  with CRC low byte.
- err_ovf  out  1  one-cycle pulse: frame longer than MAX_LEN was dropped.
- err_crc_to  out  1  one-cycle pulse: CRC result did not arrive in time.

## Operation
- States:
  - IDLE: s_ready=1. An accepted byte goes to buf[0], cnt=1, and the state moves to LOAD.
  - LOAD: s_ready=1.
    - While s_valid=1 and cnt<MAX_LEN: write buf[cnt], cnt++.
    - While s_valid=1 and cnt==MAX_LEN: set the ovf flag and discard the byte from the buffer. The byte is still forwarded to the CRC engine so crc_valid stays contiguous.
    - When s_valid=0: go to WAIT_CRC.
  - WAIT_CRC: s_ready=0, and a timer counts cycles.
    - crc_in_valid=1 with ovf set: pulse err_ovf, clear ovf, go to IDLE with no output.
    - crc_in_valid=1 with ovf clear: latch crc_in into crc_q, set rd=0, go to SEND_HDR.
    - Timer reaches CRC_TO: pulse err_crc_to, go to IDLE with no output.
  - SEND_HDR: m_valid=1, m_data=buf[rd], m_sop=(rd==0). rd advances on m_ready. After byte cnt-1 is accepted, go to SEND_CRC_H.
  - SEND_CRC_H: m_data=crc_q[15:8]; on m_ready go to SEND_CRC_L.
  - SEND_CRC_L: m_data=crc_q[7:0], m_eop=1; on m_ready go to IDLE.
- CRC feed: crc_data<=s_data and crc_valid<=s_valid&s_ready, registered every cycle. crc_valid is never high outside a frame's burst.
- s_valid while s_ready=0 is ignored: nothing is stored or forwarded.
- Output stability: m_data, m_sop and m_eop hold while m_valid=1 and m_ready=0.
- Frame length: 1..MAX_LEN bytes, so output is 3..MAX_LEN+2 bytes. A 1-byte frame asserts m_sop on the header byte only.
- crc_in_valid outside WAIT_CRC is ignored.

## Timing
- All outputs are registered or decoded from the state register. There are no combinational input-to-output paths except m_ready gating the advance.
- Reset values: state=IDLE, s_ready=1, crc_valid=0, crc_data=0, m_valid=0, m_data=0, m_sop=0, m_eop=0, err_ovf=0, err_crc_to=0, cnt=0, rd=0, ovf=0, crc_q=0.
- Last byte accepted at edge k: s_valid low sampled at k+1, CRC engine pulses crc_out_valid after k+2, the framer latches it at k+3, and m_valid=1 after k+3.
- With m_ready held high: one byte per cycle, frame occupies cnt+2 cycles, and s_ready=1 the cycle after the m_eop handshake.
- Reset mid-frame: the asynchronous return to IDLE drops the frame with no error pulse. The CRC engine shares rst_n.

## Test plan
- 4-byte frame 11,22,33,44; stub answers crc_in=BEEF at k+2; m_ready=1 → crc_valid high for 4 cycles delayed by 1; output 11(sop),22,33,44,BE,EF(eop) starting k+3, consecutive cycles.
- Same frame with m_ready toggling 1,0,0,1,... → identical byte sequence; m_data held stable across stalls; no byte lost or duplicated.
- 1-byte frame A5, crc_in=1234 → A5(sop),12,34(eop).
- 34-byte frame (MAX_LEN=32) → crc_valid high for 34 cycles; err_ovf pulses on crc_in_valid; no m_valid; next frame 01,02 with crc_in=ABCD → 01,02,AB,CD.
- Stub never asserts crc_in_valid → err_crc_to pulses CRC_TO=15 cycles after WAIT_CRC entry; s_ready returns high the next cycle.
- rst_n low during SEND_HDR byte 2 → all outputs go to reset values immediately; a following 2-byte frame is framed correctly.
